// File: rtl/rr_pop_arbiter_pkg.sv
// Shared helpers for round-robin arbiters: pointer wrap increment and grant-width derivation.
package rr_pop_arbiter_pkg;

    // Wrap by explicit compare against n-1 so non-power-of-two port counts work.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr >= n - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic int unsigned rr_grant_w(input int unsigned n);
        return (n <= 1) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pop_arbiter_pick.sv
// Combinational rotate-and-priority-encode: first set req bit at or after ptr, modulo NUM_PORTS.
module rr_pick #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned GRANT_W   = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GRANT_W-1:0]   ptr,
    output logic                 found,
    output logic [GRANT_W-1:0]   idx
);

    logic [GRANT_W:0]   sum;
    logic [GRANT_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum = {1'b0, ptr} + (GRANT_W + 1)'(k);
            // ptr < NUM_PORTS and k < NUM_PORTS, so one subtraction always suffices.
            if (sum >= (GRANT_W + 1)'(NUM_PORTS)) begin
                sum = sum - (GRANT_W + 1)'(NUM_PORTS);
            end
            cand = sum[GRANT_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_pop_arbiter.sv
// Round-robin drain of NUM_PORTS FIFO pop interfaces into one registered output stream.
module rr_pop_arbiter
    import rr_pop_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 4,
    parameter  int unsigned WIDTH     = 8,
    localparam int unsigned GRANT_W   = rr_grant_w(NUM_PORTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PORTS-1:0]       in_valid,
    input  logic [NUM_PORTS*WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [GRANT_W-1:0]         out_grant,
    input  logic                       out_ready
);

    logic [GRANT_W-1:0] ptr_q, ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [GRANT_W-1:0] out_grant_q, out_grant_d;

    logic               found;
    logic [GRANT_W-1:0] pick;
    logic               can_load;
    logic               pop;
    logic [WIDTH-1:0]   pick_data;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .GRANT_W   (GRANT_W)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick)
    );

    always_comb begin
        can_load  = !out_valid_q || out_ready;
        // Gating with rst_n keeps pops off while the upstream FIFOs are also held in reset.
        pop       = found && can_load && rst_n;
        in_ready  = '0;
        pick_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick == GRANT_W'(i)) begin
                pick_data   = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = pop;
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_grant_d = out_grant_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = pick_data;
            out_grant_d = pick;
            ptr_d       = GRANT_W'(rr_next(32'(pick), NUM_PORTS));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_grant_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_grant_q <= out_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_grant = out_grant_q;

endmodule

// File: tb/tb_rr_pop_arbiter.sv
// Bench for rr_pop_arbiter: a 4-port and a 3-port instance driven together against a reference model.
module tb_rr_pop_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [7:0]  dat [4];
    logic [31:0] in_data;
    logic        out_ready;

    logic [3:0]  in_ready4;
    logic        out_valid4;
    logic [7:0]  out_data4;
    logic [1:0]  out_grant4;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_grant3;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance (0: 4 ports, 1: 3 ports).
    int       m_ptr [2];
    bit       m_ov  [2];
    int       m_od  [2];
    int       m_og  [2];
    const int NPORT [2] = '{4, 3};

    always #5 clk = ~clk;

    assign in_data = {dat[3], dat[2], dat[1], dat[0]};

    rr_pop_arbiter #(.NUM_PORTS(4), .WIDTH(8)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready4),
        .out_valid (out_valid4),
        .out_data  (out_data4),
        .out_grant (out_grant4),
        .out_ready (out_ready)
    );

    rr_pop_arbiter #(.NUM_PORTS(3), .WIDTH(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[2:0]),
        .in_data   (in_data[23:0]),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_grant (out_grant3),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // First valid port scanning from p upward, modulo n; -1 when nothing is valid.
    function automatic int model_pick(input int n, input int p, input logic [3:0] v);
        for (int k = 0; k < n; k++) begin
            if (v[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    function automatic int model_ready(input int d);
        int p;
        if (rst_n !== 1'b1) return 0;
        if (m_ov[d] && !out_ready) return 0;
        p = model_pick(NPORT[d], m_ptr[d], in_valid);
        return (p < 0) ? 0 : (1 << p);
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_ov[d] = 0; m_od[d] = 0; m_og[d] = 0;
        end
    endfunction

    function automatic void model_clock();
        int p;
        for (int d = 0; d < 2; d++) begin
            p = model_pick(NPORT[d], m_ptr[d], in_valid);
            if ((!m_ov[d] || out_ready) && p >= 0) begin
                m_ov[d]  = 1;
                m_od[d]  = int'(dat[p]);
                m_og[d]  = p;
                m_ptr[d] = (p + 1) % NPORT[d];
            end else if (out_ready) begin
                m_ov[d] = 0;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, " valid4"}, int'(out_valid4), int'(m_ov[0]));
        check({tag, " data4"},  int'(out_data4),  m_od[0]);
        check({tag, " grant4"}, int'(out_grant4), m_og[0]);
        check({tag, " ptr4"},   int'(dut4.ptr_q), m_ptr[0]);
        check({tag, " valid3"}, int'(out_valid3), int'(m_ov[1]));
        check({tag, " data3"},  int'(out_data3),  m_od[1]);
        check({tag, " grant3"}, int'(out_grant3), m_og[1]);
        check({tag, " ptr3"},   int'(dut3.ptr_q), m_ptr[1]);
    endtask

    // Called at a falling edge with inputs already applied; ends on the next falling edge.
    task automatic do_cycle(input string tag);
        #1;
        check({tag, " ready4"}, int'(in_ready4), model_ready(0));
        check({tag, " ready3"}, int'(in_ready3), model_ready(1));
        @(posedge clk);
        if (rst_n === 1'b1) model_clock();
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic set_inputs(input logic [3:0] v, input logic r);
        in_valid  = v;
        out_ready = r;
    endtask

    initial begin
        rst_n = 1'b0;
        set_inputs(4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) dat[i] = 8'(8'h10 + i);
        model_reset();

        // Reset held with requests pending: no pops allowed.
        @(negedge clk);
        do_cycle("in_reset");
        do_cycle("in_reset");

        set_inputs(4'b0000, 1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) do_cycle("idle");

        // All ports valid, sink always ready: grants rotate 0..N-1.
        set_inputs(4'b1111, 1'b1);
        for (int c = 0; c < 8; c++) begin
            do_cycle("rotate");
            check("rotate seq4", int'(out_grant4), c % 4);
            check("rotate seq3", int'(out_grant3), c % 3);
            check("rotate dat4", int'(out_data4), 8'h10 + (c % 4));
        end

        // Single requester on port 2.
        set_inputs(4'b0100, 1'b1);
        for (int c = 0; c < 4; c++) begin
            do_cycle("single");
            check("single ptr4", int'(dut4.ptr_q), 3);
            check("single ptr3", int'(dut3.ptr_q), 0);
        end

        // Asynchronous reset while a port-2 beat is presented.
        check("pre_rst grant4", int'(out_grant4), 2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst valid4", int'(out_valid4), 0);
        check("async_rst valid3", int'(out_valid3), 0);
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // First beat from port 0, then stall the sink for 4 cycles.
        set_inputs(4'b1111, 1'b1);
        do_cycle("post_rst");
        check("post_rst grant4", int'(out_grant4), 0);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            do_cycle("stall");
            check("stall ready4", int'(in_ready4), 0);
            check("stall grant4", int'(out_grant4), 0);
        end
        out_ready = 1'b1;
        do_cycle("release");
        check("release grant4", int'(out_grant4), 1);

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
            do_cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rr_pop_arbiter.md
# rr_pop_arbiter

Round-robin arbiter that drains up to NUM_PORTS upstream `fifo` pop interfaces into one registered output stream. It sits directly downstream of the per-caller FIFOs feeding a shared module. It pops at most one entry per cycle, chosen fairly among non-empty FIFOs. Its output stream pushes into the consumer's input FIFO or drives its trigger.

## Interface
- NUM_PORTS, default 4: number of upstream FIFOs; legal range 2..16.
- WIDTH, default 8: payload width per entry.
- GRANT_W, default $clog2(NUM_PORTS): width of the grant index; derived, not overridden.

- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  NUM_PORTS  bit i = FIFO i pop_valid.
- in_data  input  NUM_PORTS*WIDTH  slice i = FIFO i pop_data, bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_PORTS  bit i = FIFO i pop_ready; combinational; at most one bit high.
- out_valid  output  1  registered output beat present.
- out_data  output  WIDTH  registered payload.
- out_grant  output  GRANT_W  index of the port that supplied out_data.
- out_ready  input  1  downstream accepts the beat this cycle.

## Operation
- State: priority pointer `ptr` (GRANT_W bits), output register {out_valid, out_data, out_grant}.
- can_load = !out_valid || out_ready.
- Pick: first i with in_valid[i], scanning ptr, ptr+1, … modulo NUM_PORTS. Wrap-around uses explicit compare against NUM_PORTS-1, never 2^GRANT_W, so non-power-of-two NUM_PORTS works.
- in_ready[pick] = can_load && any(in_valid). All other bits are 0. in_ready never depends on out_valid alone when out_ready=1.
- On a pop (in_valid[pick] && in_ready[pick]):
  - out_valid<=1, out_data<=in_data[pick], out_grant<=pick.
  - ptr<=pick+1 with wrap: pick=NUM_PORTS-1 sets ptr to 0.
- out_ready=1 with no pop: out_valid<=0. out_data and out_grant hold their old values.
- out_valid=1 and out_ready=0: the register holds. All in_ready=0 and ptr is unchanged.
- No in_valid bits set: no pop and ptr unchanged.
- Out_ready high and a new pop in the same cycle: the old beat retires and the new beat loads. Sustained throughput is 1 beat/cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_grant=0, ptr=0, in_ready=0 while rst_n=0.
- Latency: pop in cycle N gives out_valid in cycle N+1.
- A held beat is stable (data and grant) until accepted.
- Reset asserted mid-operation clears everything immediately. The held beat is lost, and the upstream FIFOs are reset by the same rst_n.
- Fairness: with all ports continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0. No port waits more than NUM_PORTS-1 pops.

## Structure
- Shared runtime package: function `rr_next(ptr, n)` for wrap increment and a GRANT_W derivation function. These are shared with any future arbiters.
- One combinational sub-module, `rr_pick`, with inputs req[NUM_PORTS] and ptr, and outputs found and idx. It contains the rotate-and-priority-encode logic, so the pick can be unit-tested on its own.
- The top level holds ptr, the output register and the in_ready gating.

## Test plan
- Reset release with all inputs idle → out_valid=0, in_ready=0000, ptr=0 for 5 cycles.
- in_valid=1111, data i=0x10+i, out_ready=1 for 8 cycles → out_grant sequence 0,1,2,3,0,1,2,3, with out_data 0x10..0x13 repeating, one beat per cycle starting 1 cycle after the first pop.
- in_valid=0100 continuously, out_ready=1 → in_ready=0100 every cycle; each beat has out_grant=2 and ptr=3 after each pop.
- in_valid=1111 with out_ready=0 for 4 cycles after the first beat → out_valid=1 and out_grant=0 held, in_ready=0000. Release out_ready → next grant is 1.
- NUM_PORTS=3, in_valid=111 → grants 0,1,2,0. ptr never reaches 3.
- rst_n pulsed low while out_valid=1 and out_grant=2 → out_valid=0 asynchronously. After release the first grant is port 0.
